// File: rtl/nonce_dispatcher.sv
// -----------------------------------------------------------------------------
// nonce_dispatcher
//
// Purpose:
//   Walks a nonce range for one mining job. Each attempt presents
//   {header template, nonce} to the miner and waits for the miner's verdict.
//   The walk ends on a hit, which gives a one-cycle found_valid pulse and
//   latches found_nonce. It also ends when the last nonce misses, which gives
//   a one-cycle exhausted pulse, or when the job is aborted, which returns to
//   IDLE silently. Nonces advance by NONCE_STEP and wrap mod 2^32, so a range
//   with start > end crosses 0xFFFFFFFF -> 0x00000000.
//
// Configuration:
//   HASH_COUNT_EN - when defined, hash_count counts accepted attempts for the
//                   current job. When undefined, hash_count is tied to zero
//                   and no counter logic is built.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   job_valid    in   new job offered
//   job_ready    out  job accepted this cycle if job_valid (IDLE only)
//   job_header   in   608-bit header template, nonce excluded
//   nonce_start  in   first nonce to try
//   nonce_end    in   last nonce to try, inclusive
//   abort        in   cancel the current job
//   hash_header  out  {template, current nonce} presented to the miner
//   hash_valid   out  hash_header is valid (ISSUE)
//   hash_ready   in   miner accepts hash_header
//   result_valid in   miner finished the accepted header
//   result_hit   in   finished hash met difficulty (qualified by result_valid)
//   found_valid  out  one-cycle winning-nonce pulse
//   found_nonce  out  winning nonce, held until the next job is accepted
//   exhausted    out  one-cycle range-done-without-hit pulse
//   busy         out  high in any state other than IDLE
//   hash_count   out  attempt counter (zero unless HASH_COUNT_EN)
// -----------------------------------------------------------------------------
module nonce_dispatcher #(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_header,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         abort,
    output logic [639:0] hash_header,
    output logic         hash_valid,
    input  logic         hash_ready,
    input  logic         result_valid,
    input  logic         result_hit,
    output logic         found_valid,
    output logic [31:0]  found_nonce,
    output logic         exhausted,
    output logic         busy,
    output logic [31:0]  hash_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t         state_r;
    logic [607:0]   template_r;
    logic [31:0]    nonceCur_r;
    logic [31:0]    nonceEnd_r;
    logic [31:0]    foundNonce_r;
    logic           jobReady_r;
    logic           hashValid_r;
    logic           foundValid_r;
    logic           exhausted_r;
    logic           busy_r;

    // Job FSM with registered handshake/status outputs and per-job datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            template_r   <= 608'd0;
            nonceCur_r   <= 32'd0;
            nonceEnd_r   <= 32'd0;
            foundNonce_r <= 32'd0;
            jobReady_r   <= 1'b1;
            hashValid_r  <= 1'b0;
            foundValid_r <= 1'b0;
            exhausted_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // Pulses last exactly one cycle; they are only re-armed on entry to REPORT.
            foundValid_r <= 1'b0;
            exhausted_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (job_valid) begin
                        template_r   <= job_header;
                        nonceCur_r   <= nonce_start;
                        nonceEnd_r   <= nonce_end;
                        foundNonce_r <= 32'd0;
                        jobReady_r   <= 1'b0;
                        hashValid_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ISSUE;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        hashValid_r <= 1'b0;
                        jobReady_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else if (hash_ready) begin
                        hashValid_r <= 1'b0;
                        state_r     <= WAIT;
                    end else begin
                        state_r     <= ISSUE;
                    end
                end
                WAIT: begin
                    if (result_valid && result_hit) begin
                        // A hit outranks a coincident abort.
                        foundNonce_r <= nonceCur_r;
                        foundValid_r <= 1'b1;
                        state_r      <= REPORT;
                    end else if (result_valid && !abort && (nonceCur_r == nonceEnd_r)) begin
                        exhausted_r  <= 1'b1;
                        state_r      <= REPORT;
                    end else if (result_valid && !abort) begin
                        // Equality test against the end nonce makes wrapping ranges work.
                        nonceCur_r   <= nonceCur_r + NONCE_STEP;
                        hashValid_r  <= 1'b1;
                        state_r      <= ISSUE;
                    end else if (abort) begin
                        jobReady_r   <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= WAIT;
                    end
                end
                REPORT: begin
                    jobReady_r <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    jobReady_r  <= 1'b1;
                    hashValid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef HASH_COUNT_EN
    logic [31:0] hashCount_r;

    // Attempt counter: cleared on job accept, bumped on each ISSUE-to-WAIT handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            hashCount_r <= 32'd0;
        end else if ((state_r == IDLE) && job_valid) begin
            hashCount_r <= 32'd0;
        end else if ((state_r == ISSUE) && hash_ready && !abort) begin
            hashCount_r <= hashCount_r + 32'd1;
        end else begin
            hashCount_r <= hashCount_r;
        end
    end

    assign hash_count = hashCount_r;
`else
    assign hash_count = 32'd0;
`endif

    assign job_ready   = jobReady_r;
    assign hash_valid  = hashValid_r;
    assign hash_header = {template_r, nonceCur_r};
    assign found_valid = foundValid_r;
    assign found_nonce = foundNonce_r;
    assign exhausted   = exhausted_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_nonce_dispatcher
//
// Directed self-checking bench for nonce_dispatcher. Inputs are driven and
// outputs are sampled on the falling clock edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_nonce_dispatcher;

    logic         clock = 1'b0;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [607:0] job_header;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic         abort;
    logic [639:0] hash_header;
    logic         hash_valid;
    logic         hash_ready;
    logic         result_valid;
    logic         result_hit;
    logic         found_valid;
    logic [31:0]  found_nonce;
    logic         exhausted;
    logic         busy;
    logic [31:0]  hash_count;

    int testCount = 0;
    int failCount = 0;
    int foundPulses = 0;
    int exhPulses = 0;
    int foundBefore;
    int exhBefore;

    localparam logic [607:0] HDR_A = {19{32'hDEAD_BEEF}};
    localparam logic [607:0] HDR_B = {19{32'h1234_5678}};

    nonce_dispatcher #(.NONCE_STEP(32'd1)) dut (
        .clock        (clock),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_header   (job_header),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .abort        (abort),
        .hash_header  (hash_header),
        .hash_valid   (hash_valid),
        .hash_ready   (hash_ready),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .found_valid  (found_valid),
        .found_nonce  (found_nonce),
        .exhausted    (exhausted),
        .busy         (busy),
        .hash_count   (hash_count)
    );

    always #5 clock = ~clock;

    // Count output pulses seen at each rising edge
    always @(posedge clock) begin
        if (found_valid) foundPulses <= foundPulses + 1;
        if (exhausted)   exhPulses   <= exhPulses + 1;
    end

    task automatic checkVal(input string tag, input logic [639:0] act, input logic [639:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic startJob(input logic [607:0] hdr, input logic [31:0] s, input logic [31:0] e);
        job_header  = hdr;
        nonce_start = s;
        nonce_end   = e;
        job_valid   = 1'b1;
        tick();
        job_valid   = 1'b0;
    endtask

    // One handshake plus result; caller checks the outcome afterwards
    task automatic attempt(input string tag, input logic [31:0] expNonce, input logic hit);
        checkVal({tag, "_hv"}, {639'd0, hash_valid}, 640'd1);
        checkVal({tag, "_nonce"}, {608'd0, hash_header[31:0]}, {608'd0, expNonce});
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        checkVal({tag, "_wait_hv"}, {639'd0, hash_valid}, 640'd0);
        result_valid = 1'b1;
        result_hit   = hit;
        tick();
        result_valid = 1'b0;
        result_hit   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; job_valid = 1'b0; job_header = 608'd0; nonce_start = 32'd0;
        nonce_end = 32'd0; abort = 1'b0; hash_ready = 1'b0; result_valid = 1'b0;
        result_hit = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        checkVal("rst_job_ready", {639'd0, job_ready}, 640'd1);
        checkVal("rst_hash_valid", {639'd0, hash_valid}, 640'd0);
        checkVal("rst_busy", {639'd0, busy}, 640'd0);
        checkVal("rst_found_valid", {639'd0, found_valid}, 640'd0);
        checkVal("rst_exhausted", {639'd0, exhausted}, 640'd0);
        checkVal("rst_header", hash_header, 640'd0);
        checkVal("rst_found_nonce", {608'd0, found_nonce}, 640'd0);

        // Hit case: third attempt hits
        startJob(HDR_A, 32'h42a1_4693, 32'h42a1_46A0);
        checkVal("hit_busy", {639'd0, busy}, 640'd1);
        checkVal("hit_job_ready", {639'd0, job_ready}, 640'd0);
        checkVal("hit_header", hash_header, {HDR_A, 32'h42a1_4693});
        attempt("hit_a0", 32'h42a1_4693, 1'b0);
        attempt("hit_a1", 32'h42a1_4694, 1'b0);
        attempt("hit_a2", 32'h42a1_4695, 1'b1);
        checkVal("hit_found_valid", {639'd0, found_valid}, 640'd1);
        checkVal("hit_found_nonce", {608'd0, found_nonce}, {608'd0, 32'h42a1_4695});
        checkVal("hit_report_ready", {639'd0, job_ready}, 640'd0);
        checkVal("hit_no_exh", {639'd0, exhausted}, 640'd0);
`ifdef HASH_COUNT_EN
        checkVal("hit_count", {608'd0, hash_count}, {608'd0, 32'd3});
`else
        checkVal("hit_count", {608'd0, hash_count}, 640'd0);
`endif
        tick();
        checkVal("hit_pulse_end", {639'd0, found_valid}, 640'd0);
        checkVal("hit_idle_ready", {639'd0, job_ready}, 640'd1);
        checkVal("hit_idle_busy", {639'd0, busy}, 640'd0);
        checkVal("hit_nonce_held", {608'd0, found_nonce}, {608'd0, 32'h42a1_4695});

        // Exhaust case: four misses; a job offered mid-run must be ignored
        tick();
        foundBefore = foundPulses;
        exhBefore   = exhPulses;
        startJob(HDR_B, 32'h10, 32'h13);
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        job_valid = 1'b1; nonce_start = 32'h777; nonce_end = 32'h777;
        tick();
        job_valid = 1'b0;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        checkVal("exh_hdr_kept", hash_header, {HDR_B, 32'h11});
        attempt("exh_a1", 32'h11, 1'b0);
        attempt("exh_a2", 32'h12, 1'b0);
        attempt("exh_a3", 32'h13, 1'b0);
        checkVal("exh_pulse", {639'd0, exhausted}, 640'd1);
        checkVal("exh_no_found", {639'd0, found_valid}, 640'd0);
        tick();
        checkVal("exh_pulse_end", {639'd0, exhausted}, 640'd0);
        checkVal("exh_idle", {639'd0, job_ready}, 640'd1);
        tick();
        checkVal("exh_found_cnt", foundPulses - foundBefore, 640'd0);
        checkVal("exh_exh_cnt", exhPulses - exhBefore, 640'd1);

        // Wrap case
        startJob(HDR_A, 32'hFFFF_FFFE, 32'h0000_0001);
        attempt("wrap_a0", 32'hFFFF_FFFE, 1'b0);
        attempt("wrap_a1", 32'hFFFF_FFFF, 1'b0);
        attempt("wrap_a2", 32'h0000_0000, 1'b0);
        attempt("wrap_a3", 32'h0000_0001, 1'b0);
        checkVal("wrap_exh", {639'd0, exhausted}, 640'd1);
        tick();

        // Single-nonce range: exactly one attempt
        startJob(HDR_B, 32'h55, 32'h55);
        attempt("one_a0", 32'h55, 1'b0);
        checkVal("one_exh", {639'd0, exhausted}, 640'd1);
        tick();

        // Backpressure: header stable for 5 cycles, stray result ignored in ISSUE
        startJob(HDR_B, 32'hABCD_0000, 32'hABCD_0010);
        for (int i = 0; i < 5; i++) begin
            result_valid = (i == 2);
            result_hit   = (i == 2);
            tick();
            checkVal($sformatf("bp_hv%0d", i), {639'd0, hash_valid}, 640'd1);
            checkVal($sformatf("bp_hdr%0d", i), hash_header, {HDR_B, 32'hABCD_0000});
        end
        result_valid = 1'b0; result_hit = 1'b0;
        checkVal("bp_no_found", {639'd0, found_valid}, 640'd0);
        attempt("bp_a0", 32'hABCD_0000, 1'b1);
        checkVal("bp_found", {608'd0, found_nonce}, {608'd0, 32'hABCD_0000});
        tick();

        // Abort colliding with a hit: hit wins
        startJob(HDR_A, 32'h5, 32'h9);
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        abort = 1'b1; result_valid = 1'b1; result_hit = 1'b1;
        tick();
        abort = 1'b0; result_valid = 1'b0; result_hit = 1'b0;
        checkVal("abhit_found", {639'd0, found_valid}, 640'd1);
        checkVal("abhit_nonce", {608'd0, found_nonce}, {608'd0, 32'h5});
        tick();

        // Abort colliding with a miss, then abort in ISSUE: silent return to IDLE
        tick();
        foundBefore = foundPulses;
        exhBefore   = exhPulses;
        startJob(HDR_A, 32'h5, 32'h9);
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        abort = 1'b1; result_valid = 1'b1;
        tick();
        abort = 1'b0; result_valid = 1'b0;
        checkVal("abmiss_busy", {639'd0, busy}, 640'd0);
        checkVal("abmiss_ready", {639'd0, job_ready}, 640'd1);
        startJob(HDR_A, 32'h7, 32'h7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkVal("abissue_busy", {639'd0, busy}, 640'd0);
        checkVal("abissue_hv", {639'd0, hash_valid}, 640'd0);
        tick();
        checkVal("abort_no_pulses", (foundPulses - foundBefore) + (exhPulses - exhBefore), 640'd0);

        // Reset in WAIT
        startJob(HDR_B, 32'h20, 32'h30);
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        foundBefore = foundPulses;
        exhBefore   = exhPulses;
        reset = 1'b1; result_valid = 1'b1; result_hit = 1'b1;
        tick();
        reset = 1'b0; result_valid = 1'b0; result_hit = 1'b0;
        checkVal("rw_busy", {639'd0, busy}, 640'd0);
        checkVal("rw_ready", {639'd0, job_ready}, 640'd1);
        checkVal("rw_found_nonce", {608'd0, found_nonce}, 640'd0);
        checkVal("rw_header", hash_header, 640'd0);
        tick(); tick();
        checkVal("rw_no_pulses", (foundPulses - foundBefore) + (exhPulses - exhBefore), 640'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
